// File: rtl/bcd_disp_pkg.sv
// Shared display codes, FSM state type and internal BCD sizing for the
// binary-to-BCD digit converter.
package bcd_disp_pkg;

  localparam logic [3:0] DIG_H     = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hB;
  localparam logic [3:0] DIG_DASH  = 4'hC;

  typedef enum logic [1:0] {IDLE, SHIFT, FIX} state_t;

  // Decimal digits needed to hold any WIDTH-bit unsigned value (log10(2) ~ 0.301).
  function automatic int nint(input int width);
    return width * 301 / 1000 + 1;
  endfunction

endpackage

// File: rtl/dd_add3.sv
// Double-dabble correction step: every BCD digit >= 5 gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module dd_add3 #(
  parameter int N = 1
) (
  input  logic [N*4-1:0] din,
  output logic [N*4-1:0] dout
);

  always_comb begin
    dout = din;
    for (int i = 0; i < N; i++) begin
      if (din[i*4 +: 4] >= 4'd5) dout[i*4 +: 4] = din[i*4 +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter for the seven-segment path: one input bit
// per clock, then a single output-formatting cycle (sentinels, overflow, blanking).
module bcd_digit_converter
  import bcd_disp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 4,
  parameter int LZ_BLANK = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        number,
  output logic                    out_valid,
  output logic                    overflow,
  output logic [DIGITS-1:0][3:0]  digit_array
);

  localparam int NINT = nint(WIDTH);
  localparam int NEXT = (NINT > DIGITS) ? NINT : DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ONES_M1 = {WIDTH{1'b1}} - WIDTH'(1);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        shreg;
  logic [WIDTH-1:0]        num_q;
  logic [NINT*4-1:0]       bcd;
  logic [NINT*4-1:0]       bcd_add;
  logic [NEXT*4-1:0]       bcd_ext;
  logic                    hi_nz;
  logic                    seen_nz;
  logic [DIGITS-1:0][3:0]  dig_nxt;
  logic                    ovf_nxt;

  dd_add3 #(.N(NINT)) u_add3 (
    .din  (bcd),
    .dout (bcd_add)
  );

  assign in_ready = (state == IDLE);

  // Datapath: operand capture at the handshake, then one double-dabble step per SHIFT cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      shreg <= number;
      num_q <= number;
      bcd   <= '0;
    end else if (state == SHIFT) begin
      {bcd, shreg} <= {bcd_add, shreg} << 1;
    end
  end

  // Output formatting evaluated from the finished BCD register and the latched operand
  always_comb begin
    bcd_ext = '0;
    bcd_ext[NINT*4-1:0] = bcd;
    hi_nz   = 1'b0;
    for (int i = DIGITS; i < NEXT; i++) begin
      hi_nz = hi_nz | (bcd_ext[i*4 +: 4] != 4'd0);
    end
    ovf_nxt = 1'b0;
    seen_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) dig_nxt[i] = bcd_ext[i*4 +: 4];
    if (num_q == ALL_ONES) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig_nxt[i] = (i == 0) ? 4'd1 : (i == 1) ? DIG_H : DIG_BLANK;
      end
    end else if (num_q == ALL_ONES_M1) begin
      dig_nxt = {DIGITS{DIG_BLANK}};
    end else if (hi_nz) begin
      dig_nxt = {DIGITS{DIG_DASH}};
      ovf_nxt = 1'b1;
    end else if (LZ_BLANK != 0) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (!seen_nz && dig_nxt[i] == 4'd0) dig_nxt[i] = DIG_BLANK;
        else seen_nz = 1'b1;
      end
    end
  end

  // Control: FSM, bit counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      digit_array <= {DIGITS{DIG_BLANK}};
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          digit_array <= dig_nxt;
          overflow    <= ovf_nxt;
          out_valid   <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Directed bench for bcd_digit_converter: three instances cover the default
// configuration, leading-zero blanking and a narrow 8-bit/2-digit build.
module tb_bcd_digit_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              iv0, ir0, ov0, of0;
  logic [31:0]       num0;
  logic [3:0][3:0]   dg0;
  logic              iv1, ir1, ov1, of1;
  logic [31:0]       num1;
  logic [3:0][3:0]   dg1;
  logic              iv2, ir2, ov2, of2;
  logic [7:0]        num2;
  logic [1:0][3:0]   dg2;

  int checks = 0;
  int failures = 0;

  bcd_digit_converter #(.WIDTH(32), .DIGITS(4), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .number(num0),
    .out_valid(ov0), .overflow(of0), .digit_array(dg0));

  bcd_digit_converter #(.WIDTH(32), .DIGITS(4), .LZ_BLANK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .number(num1),
    .out_valid(ov1), .overflow(of1), .digit_array(dg1));

  bcd_digit_converter #(.WIDTH(8), .DIGITS(2), .LZ_BLANK(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .number(num2),
    .out_valid(ov2), .overflow(of2), .digit_array(dg2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a conversion in the current cycle; returns in the out_valid cycle.
  task automatic conv0(input string tag, input logic [31:0] v, input logic [15:0] ed,
                       input logic eo, input bit pulse);
    int n;
    int rdy_bad;
    num0 = v;
    iv0  = 1'b1;
    @(posedge clk); #1;
    iv0  = 1'b0;
    num0 = 32'h0000_1111;
    n = 0;
    rdy_bad = 0;
    while (ov0 !== 1'b1 && n < 200) begin
      if (ir0 !== 1'b0) rdy_bad++;
      if (pulse && n == 5) begin
        iv0  = 1'b1;
        num0 = 32'd7777;
      end else begin
        iv0 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    iv0 = 1'b0;
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_digits"}, {16'h0, dg0}, {16'h0, ed});
    chk({tag, "_ovf"}, {31'h0, of0}, {31'h0, eo});
    chk({tag, "_busy_ready"}, rdy_bad, 0);
    chk({tag, "_ready_at_valid"}, {31'h0, ir0}, 32'd1);
  endtask

  task automatic conv1(input string tag, input logic [31:0] v, input logic [15:0] ed);
    int n;
    num1 = v;
    iv1  = 1'b1;
    @(posedge clk); #1;
    iv1  = 1'b0;
    n = 0;
    while (ov1 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_digits"}, {16'h0, dg1}, {16'h0, ed});
    chk({tag, "_ovf"}, {31'h0, of1}, 32'd0);
  endtask

  task automatic conv2(input string tag, input logic [7:0] v, input logic [7:0] ed, input logic eo);
    int n;
    num2 = v;
    iv2  = 1'b1;
    @(posedge clk); #1;
    iv2  = 1'b0;
    n = 0;
    while (ov2 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_digits"}, {24'h0, dg2}, {24'h0, ed});
    chk({tag, "_ovf"}, {31'h0, of2}, {31'h0, eo});
  endtask

  initial begin
    int seen;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    num0 = '0; num1 = '0; num2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, ir0}, 32'd1);
    chk("rst_valid", {31'h0, ov0}, 32'd0);
    chk("rst_ovf", {31'h0, of0}, 32'd0);
    chk("rst_digits", {16'h0, dg0}, 32'h0000_BBBB);
    chk("rst_digits_w8", {24'h0, dg2}, 32'h0000_00BB);
    rst_n = 1'b1;
    @(posedge clk); #1;

    conv0("d1234", 32'd1234, 16'h1234, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("valid_one_cycle", {31'h0, ov0}, 32'd0);
    chk("hold_digits", {16'h0, dg0}, 32'h0000_1234);
    conv0("d9999", 32'd9999, 16'h9999, 1'b0, 1'b0);
    conv0("d10000", 32'd10000, 16'hCCCC, 1'b1, 1'b0);
    conv0("dFFFD", 32'hFFFF_FFFD, 16'hCCCC, 1'b1, 1'b0);
    conv0("sent_h1", 32'hFFFF_FFFF, 16'hBBA1, 1'b0, 1'b0);
    conv0("sent_blank", 32'hFFFF_FFFE, 16'hBBBB, 1'b0, 1'b0);
    conv0("d7", 32'd7, 16'h0007, 1'b0, 1'b0);
    conv0("b2b_42", 32'd42, 16'h0042, 1'b0, 1'b1);
    conv0("b2b_4321", 32'd4321, 16'h4321, 1'b0, 1'b1);
    conv0("d0", 32'd0, 16'h0000, 1'b0, 1'b0);
    conv0("d56789", 32'd56789, 16'hCCCC, 1'b1, 1'b0);

    num0 = 32'd5678;
    iv0  = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, ir0}, 32'd1);
    chk("midrst_valid", {31'h0, ov0}, 32'd0);
    chk("midrst_ovf", {31'h0, of0}, 32'd0);
    chk("midrst_digits", {16'h0, dg0}, 32'h0000_BBBB);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov0 !== 1'b0) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    conv0("after_rst_8", 32'd8, 16'h0008, 1'b0, 1'b0);

    conv1("lz_0", 32'd0, 16'hBBB0);
    conv1("lz_7", 32'd7, 16'hBBB7);
    conv1("lz_105", 32'd105, 16'hB105);
    conv1("lz_1000", 32'd1000, 16'h1000);

    conv2("w8_99", 8'd99, 8'h99, 1'b0);
    conv2("w8_100", 8'd100, 8'hCC, 1'b1);
    conv2("w8_253", 8'd253, 8'hCC, 1'b1);
    conv2("w8_255", 8'd255, 8'hA1, 1'b0);
    conv2("w8_254", 8'd254, 8'hBB, 1'b0);
    conv2("w8_5", 8'd5, 8'h05, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
